// File: rtl/pu_div_driver_pkg.sv
// Shared encodings and helpers for the pu_div initiator: FSM states,
// result-select codes and the latency countdown width.
package pu_div_driver_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WR_B = 1'b1
  } issue_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    RD_Q   = 2'b01,
    RD_R   = 2'b10,
    CAP_R  = 2'b11
  } read_state_e;

  localparam logic RES_SEL_QUOT = 1'b0;
  localparam logic RES_SEL_REM  = 1'b1;

  function automatic int countdown_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/pu_div_latency_ring.sv
// Ring of per-division countdown slots; reports when the oldest outstanding
// division has had its full latency and whether a new job can be taken.
module pu_div_latency_ring
  import pu_div_driver_pkg::*;
#(
  parameter int DIV_LATENCY  = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic pop,
  output logic head_ready,
  output logic can_accept_next
);

  localparam int CNT_W = countdown_width(DIV_LATENCY);
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int INF_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_LATENCY);
  localparam logic [INF_W-1:0] FULL     = INF_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt_r [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [INF_W-1:0] inflight_r;
  logic [INF_W-1:0] inflight_s;

  // Next in-flight count; a launch and a retire in the same cycle cancel.
  always_comb begin
    inflight_s = inflight_r;
    case ({load, pop})
      2'b10:   inflight_s = inflight_r + INF_W'(1);
      2'b01:   inflight_s = inflight_r - INF_W'(1);
      default: inflight_s = inflight_r;
    endcase
  end

  assign head_ready      = (inflight_r != {INF_W{1'b0}}) && (cnt_r[rd_ptr_r] == {CNT_W{1'b0}});
  assign can_accept_next = (inflight_s < FULL);

  // Countdown slots: load on launch, otherwise run down to zero and hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        if (load && (wr_ptr_r == PTR_W'(i))) begin
          cnt_r[i] <= LOAD_VAL;
        end else if (cnt_r[i] != {CNT_W{1'b0}}) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Ring pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      inflight_r <= {INF_W{1'b0}};
    end else begin
      if (load) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      inflight_r <= inflight_s;
    end
  end

endmodule

// File: rtl/pu_div_driver.sv
// Initiator for a pu_div port: writes dividend/divisor per accepted job and
// reads quotient/remainder back in issue order once each latency expires.
module pu_div_driver
  import pu_div_driver_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ATTR_WIDTH   = 4,
  parameter int INVALID      = 0,
  parameter int DIV_LATENCY  = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [ATTR_WIDTH:0]   req_a_attr,
  input  logic [ATTR_WIDTH:0]   req_b_attr,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_quot,
  output logic [DATA_WIDTH-1:0] res_rem,
  output logic [ATTR_WIDTH:0]   res_attr,
  output logic [DATA_WIDTH-1:0] pu_data_in,
  output logic [ATTR_WIDTH:0]   pu_attr_in,
  output logic                  pu_signal_wr,
  output logic                  pu_signal_sel,
  output logic                  pu_signal_oe,
  output logic                  pu_res_select,
  input  logic [DATA_WIDTH-1:0] pu_data_out,
  input  logic [ATTR_WIDTH:0]   pu_attr_out
);

  issue_state_e iss_state_r;
  issue_state_e iss_next_s;
  read_state_e  rd_state_r;
  read_state_e  rd_next_s;

  logic                  req_ready_r;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] b_r;
  logic [ATTR_WIDTH:0]   b_attr_r;

  logic                  pu_wr_r;
  logic                  pu_sel_r;
  logic                  pu_oe_r;
  logic                  pu_res_sel_r;
  logic [DATA_WIDTH-1:0] pu_data_r;
  logic [ATTR_WIDTH:0]   pu_attr_r;

  logic                  wr_s;
  logic                  sel_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic [ATTR_WIDTH:0]   attr_s;
  logic                  load_s;
  logic                  oe_s;
  logic                  res_sel_s;
  logic                  pop_s;
  logic                  cap_q_s;
  logic                  cap_r_s;

  logic                  res_valid_r;
  logic [DATA_WIDTH-1:0] res_quot_r;
  logic [DATA_WIDTH-1:0] res_rem_r;
  logic [ATTR_WIDTH:0]   quot_attr_r;
  logic [ATTR_WIDTH:0]   res_attr_r;
  logic [ATTR_WIDTH:0]   attr_merge_s;

  logic                  head_ready_s;
  logic                  can_accept_next_s;

  assign accept_s = req_valid && req_ready_r;

  pu_div_latency_ring #(
    .DIV_LATENCY  (DIV_LATENCY),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_ring (
    .clk             (clk),
    .rst             (rst),
    .load            (load_s),
    .pop             (pop_s),
    .head_ready      (head_ready_s),
    .can_accept_next (can_accept_next_s)
  );

  // Issue FSM; pin values are computed here and registered, so the ring load
  // in WR_B lines up with the divisor write the pu sees one cycle later.
  always_comb begin
    iss_next_s = iss_state_r;
    wr_s       = 1'b0;
    sel_s      = 1'b0;
    data_s     = pu_data_r;
    attr_s     = pu_attr_r;
    load_s     = 1'b0;
    case (iss_state_r)
      IDLE: begin
        if (accept_s) begin
          wr_s       = 1'b1;
          sel_s      = 1'b0;
          data_s     = req_a;
          attr_s     = req_a_attr;
          iss_next_s = WR_B;
        end else begin
          iss_next_s = IDLE;
        end
      end
      WR_B: begin
        wr_s       = 1'b1;
        sel_s      = 1'b1;
        data_s     = b_r;
        attr_s     = b_attr_r;
        load_s     = 1'b1;
        iss_next_s = IDLE;
      end
      default: begin
        iss_next_s = IDLE;
      end
    endcase
  end

  // Read FSM; pu_data_out trails oe by one cycle, hence captures in RD_R/CAP_R.
  always_comb begin
    rd_next_s = rd_state_r;
    pop_s     = 1'b0;
    cap_q_s   = 1'b0;
    cap_r_s   = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        if (head_ready_s && !res_valid_r) begin
          rd_next_s = RD_Q;
        end else begin
          rd_next_s = R_IDLE;
        end
      end
      RD_Q: begin
        rd_next_s = RD_R;
      end
      RD_R: begin
        cap_q_s   = 1'b1;
        rd_next_s = CAP_R;
      end
      CAP_R: begin
        cap_r_s   = 1'b1;
        pop_s     = 1'b1;
        rd_next_s = R_IDLE;
      end
      default: begin
        rd_next_s = R_IDLE;
      end
    endcase
    oe_s      = (rd_next_s == RD_Q) || (rd_next_s == RD_R);
    res_sel_s = (rd_next_s == RD_R) ? RES_SEL_REM : RES_SEL_QUOT;
  end

  // Result attributes: union of both reads, invalid flag kept explicitly.
  always_comb begin
    attr_merge_s          = quot_attr_r | pu_attr_out;
    attr_merge_s[INVALID] = quot_attr_r[INVALID] | pu_attr_out[INVALID];
  end

  // State registers, registered pu pins and request-side ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_state_r  <= IDLE;
      rd_state_r   <= R_IDLE;
      req_ready_r  <= 1'b0;
      pu_wr_r      <= 1'b0;
      pu_sel_r     <= 1'b0;
      pu_oe_r      <= 1'b0;
      pu_res_sel_r <= RES_SEL_QUOT;
      pu_data_r    <= {DATA_WIDTH{1'b0}};
      pu_attr_r    <= {(ATTR_WIDTH+1){1'b0}};
    end else begin
      iss_state_r  <= iss_next_s;
      rd_state_r   <= rd_next_s;
      req_ready_r  <= (iss_next_s == IDLE) && can_accept_next_s;
      pu_wr_r      <= wr_s;
      pu_sel_r     <= sel_s;
      pu_oe_r      <= oe_s;
      pu_res_sel_r <= res_sel_s;
      pu_data_r    <= data_s;
      pu_attr_r    <= attr_s;
    end
  end

  // Divisor holding register for the second write cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_r      <= {DATA_WIDTH{1'b0}};
      b_attr_r <= {(ATTR_WIDTH+1){1'b0}};
    end else if (accept_s) begin
      b_r      <= req_b;
      b_attr_r <= req_b_attr;
    end
  end

  // Response holding registers; stable until the consumer takes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_r <= 1'b0;
      res_quot_r  <= {DATA_WIDTH{1'b0}};
      res_rem_r   <= {DATA_WIDTH{1'b0}};
      quot_attr_r <= {(ATTR_WIDTH+1){1'b0}};
      res_attr_r  <= {(ATTR_WIDTH+1){1'b0}};
    end else begin
      if (cap_q_s) begin
        res_quot_r  <= pu_data_out;
        quot_attr_r <= pu_attr_out;
      end
      if (cap_r_s) begin
        res_rem_r   <= pu_data_out;
        res_attr_r  <= attr_merge_s;
        res_valid_r <= 1'b1;
      end else if (res_valid_r && res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign req_ready     = req_ready_r;
  assign res_valid     = res_valid_r;
  assign res_quot      = res_quot_r;
  assign res_rem       = res_rem_r;
  assign res_attr      = res_attr_r;
  assign pu_data_in    = pu_data_r;
  assign pu_attr_in    = pu_attr_r;
  assign pu_signal_wr  = pu_wr_r;
  assign pu_signal_sel = pu_sel_r;
  assign pu_signal_oe  = pu_oe_r;
  assign pu_res_select = pu_res_sel_r;

endmodule
